// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and types shared by the fetch stage and the decode
// controller.
//   - fetch_state_t       : fetch state machine states (RUN, HALTED)
//   - NOP_INSTR_DEFAULT   : bubble instruction (addi x0,x0,0)
//   - RESET_PC_DEFAULT    : PC after reset
//   - OP_*                : 7-bit opcode field values decoded by the controller
package fetch_pkg;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_HALT   = 7'b1111111;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: every non-clock signal of the fetch stage.
//   Control from decode/execute : stall, redirect_valid, redirect_pc, halt_req
//   Instruction memory          : imem_addr (out of fetch), imem_rdata (into fetch)
//   IF/ID to decode             : if_pc, if_pc_plus4, if_instr, if_valid
//   Status                      : halted, fetch_count
// Modports: slave = the fetch unit, master = the pipeline/memory side.
interface instr_fetch_unit_if #(
  parameter int IMEM_AW = 8
);
  logic               stall;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               halt_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic [31:0]        if_pc;
  logic [31:0]        if_pc_plus4;
  logic [31:0]        if_instr;
  logic               if_valid;
  logic               halted;
  logic [31:0]        fetch_count;

  modport slave (
    input  stall, redirect_valid, redirect_pc, halt_req, imem_rdata,
    output imem_addr, if_pc, if_pc_plus4, if_instr, if_valid, halted, fetch_count
  );

  modport master (
    output stall, redirect_valid, redirect_pc, halt_req, imem_rdata,
    input  imem_addr, if_pc, if_pc_plus4, if_instr, if_valid, halted, fetch_count
  );
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk, reset (async, active-high)
//   load     : capture pc_in / pc_in+4 / instr_in, mark valid
//   flush    : replace instruction with the bubble, mark invalid (wins over load)
//   neither  : hold
//   if_pc, if_pc_plus4, if_instr, if_valid : register contents
module if_id_reg #(
  parameter logic [31:0] BUBBLE = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr,
  output logic        if_valid
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_pc       <= 32'h0;
      if_pc_plus4 <= 32'h4;
      if_instr    <= BUBBLE;
      if_valid    <= 1'b0;
    end else if (flush) begin
      // PC fields keep their last value; only the instruction becomes a bubble.
      if_instr    <= BUBBLE;
      if_valid    <= 1'b0;
    end else if (load) begin
      if_pc       <= pc_in;
      if_pc_plus4 <= pc_in + 32'd4;
      if_instr    <= instr_in;
      if_valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage. Owns the PC and the RUN/HALTED state machine,
// addresses instruction memory combinationally and loads the IF/ID register.
//   clk, reset : clock (rising edge), asynchronous active-high reset
//   bus        : instr_fetch_unit_if.slave (control in, imem, IF/ID out, status)
// Parameters: IMEM_AW (imem word-address width), RESET_PC, NOP_INSTR.
// Build option: define FETCH_COUNT_EN to get a fetched-instruction counter on
// fetch_count; without it fetch_count is constant zero.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          IMEM_AW   = 8,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.slave  bus
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         running;
  logic         halt_take;
  logic         ifid_load;
  logic         ifid_flush;

  assign running   = (state == RUN);
  // A halt request only counts for a real instruction; bubbles never halt.
  assign halt_take = bus.halt_req & bus.if_valid;
  // Redirect beats halt (halt is on the wrong path) and both beat stall.
  assign ifid_flush = running & (bus.redirect_valid | halt_take);
  assign ifid_load  = running & ~bus.redirect_valid & ~halt_take & ~bus.stall;

  assign bus.imem_addr = pc[IMEM_AW+1:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      pc         <= RESET_PC;
      bus.halted <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.redirect_valid) begin
            pc <= bus.redirect_pc & ~32'd3;
          end else if (halt_take) begin
            state      <= HALTED;
            bus.halted <= 1'b1;
          end else if (!bus.stall) begin
            pc <= pc + 32'd4;
          end
        end
        HALTED: begin
          // Frozen until reset.
        end
        default: state <= RUN;
      endcase
    end
  end

  if_id_reg #(
    .BUBBLE (NOP_INSTR)
  ) u_if_id (
    .clk         (clk),
    .reset       (reset),
    .load        (ifid_load),
    .flush       (ifid_flush),
    .pc_in       (pc),
    .instr_in    (bus.imem_rdata),
    .if_pc       (bus.if_pc),
    .if_pc_plus4 (bus.if_pc_plus4),
    .if_instr    (bus.if_instr),
    .if_valid    (bus.if_valid)
  );

`ifdef FETCH_COUNT_EN
  logic [31:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 32'h0;
    end else if (ifid_load) begin
      count <= count + 32'd1;
    end
  end

  assign bus.fetch_count = count;
`else
  assign bus.fetch_count = 32'h0;
`endif

endmodule
